// File: rtl/multi_clock_divider_if.sv
// multi_clock_divider_if: divisor write port with single-cycle accept/reject response
interface multi_clock_divider_if #(
    parameter int CH_W  = 2,
    parameter int CNT_W = 32
);
    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ack;
    logic             cfg_err;
    modport master(output cfg_we, cfg_ch, cfg_div, input cfg_ack, cfg_err);
    modport slave(input cfg_we, cfg_ch, cfg_div, output cfg_ack, cfg_err);
endinterface

// File: rtl/multi_clock_divider.sv
// multi_clock_divider: N independent square-wave/tick dividers with runtime-reloadable half-periods
module multi_clock_divider #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter logic [NUM_CH*CNT_W-1:0] DEF_DIV = {32'd25000000, 32'd50000000, 32'd6250000, 32'd100000}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              sync_clr,
    multi_clock_divider_if.slave cfg,
    output logic [NUM_CH-1:0] div_out,
    output logic [NUM_CH-1:0] tick
);
    localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    logic [CH_W-1:0] ch;
    logic            ok;
    assign ch = cfg.cfg_ch;
    assign ok = cfg.cfg_we && cfg.cfg_div != '0 && {1'b0, ch} < (CH_W+1)'(NUM_CH);
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            cfg.cfg_ack <= 1'b0;
            cfg.cfg_err <= 1'b0;
        end else begin
            cfg.cfg_ack <= ok;
            cfg.cfg_err <= cfg.cfg_we && !ok;
        end
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] act, shd, cnt, shd_nxt;
        logic             q, t;
        // sync_clr loads the shadow including a write arriving in the same cycle
        assign shd_nxt    = (ok && ch == CH_W'(g)) ? cfg.cfg_div : shd;
        assign div_out[g] = q;
        assign tick[g]    = t;
        always_ff @(posedge clk or negedge rst)
            if (!rst) begin
                cnt <= '0;
                q   <= 1'b0;
                t   <= 1'b0;
                act <= DEF_DIV[g*CNT_W +: CNT_W];
                shd <= DEF_DIV[g*CNT_W +: CNT_W];
            end else begin
                shd <= shd_nxt;
                if (sync_clr) begin
                    cnt <= '0;
                    q   <= 1'b0;
                    t   <= 1'b0;
                    act <= shd_nxt;
                end else if (run && cnt == act - 1'b1) begin
                    cnt <= '0;
                    q   <= ~q;
                    t   <= ~q;
                    act <= shd;
                end else begin
                    cnt <= run ? cnt + 1'b1 : cnt;
                    t   <= 1'b0;
                end
            end
    end
endmodule

// File: tb/tb_multi_clock_divider.sv
// tb_multi_clock_divider: directed + random stimulus against a countdown reference model
module tb_multi_clock_divider;
    localparam int NCH = 3;
    localparam int CW  = 8;
    logic clk = 1'b0, rst = 1'b0, run = 1'b0, sync_clr = 1'b0;
    logic [NCH-1:0] div_out, tick;
    int errors = 0, checks = 0;
    int m_rem[NCH], m_s[NCH];
    bit m_lvl[NCH], m_tk[NCH], m_ack, m_err;
    multi_clock_divider_if #(.CH_W(2), .CNT_W(CW)) cfg();
    multi_clock_divider #(.NUM_CH(NCH), .CNT_W(CW), .DEF_DIV({8'd7, 8'd5, 8'd3})) dut (
        .clk(clk), .rst(rst), .run(run), .sync_clr(sync_clr), .cfg(cfg),
        .div_out(div_out), .tick(tick));
    always #5 clk = ~clk;
    // Model keeps cycles remaining until the next toggle rather than an up-counter
    task automatic model_reset();
        int d[NCH] = '{3, 5, 7};
        for (int i = 0; i < NCH; i++) begin
            m_rem[i] = d[i]; m_s[i] = d[i]; m_lvl[i] = 0; m_tk[i] = 0;
        end
        m_ack = 0; m_err = 0;
    endtask
    task automatic model_step(input bit r, input bit s, input bit w, input int c, input int d);
        bit ok;
        int ns;
        ok = w && d != 0 && c < NCH;
        m_ack = ok; m_err = w && !ok;
        for (int i = 0; i < NCH; i++) begin
            ns = (ok && c == i) ? d : m_s[i];
            m_tk[i] = 0;
            if (s) begin
                m_rem[i] = ns; m_lvl[i] = 0;
            end else if (r) begin
                m_rem[i]--;
                if (m_rem[i] == 0) begin
                    m_lvl[i] = !m_lvl[i]; m_tk[i] = m_lvl[i]; m_rem[i] = m_s[i];
                end
            end
            m_s[i] = ns;
        end
    endtask
    task automatic check(input string tag);
        logic [NCH-1:0] eo, et;
        for (int i = 0; i < NCH; i++) begin eo[i] = m_lvl[i]; et[i] = m_tk[i]; end
        checks++;
        assert (div_out === eo) else begin errors++; $error("FAIL %s div_out got %b exp %b", tag, div_out, eo); end
        checks++;
        assert (tick === et) else begin errors++; $error("FAIL %s tick got %b exp %b", tag, tick, et); end
        checks++;
        assert (cfg.cfg_ack === m_ack) else begin errors++; $error("FAIL %s cfg_ack got %b exp %b", tag, cfg.cfg_ack, m_ack); end
        checks++;
        assert (cfg.cfg_err === m_err) else begin errors++; $error("FAIL %s cfg_err got %b exp %b", tag, cfg.cfg_err, m_err); end
    endtask
    task automatic cyc(input string tag, input bit r, input bit s = 0, input bit w = 0,
                       input int c = 0, input int d = 0);
        run = r; sync_clr = s; cfg.cfg_we = w; cfg.cfg_ch = 2'(c); cfg.cfg_div = CW'(d);
        @(posedge clk);
        model_step(r, s, w, c, d);
        #1 check(tag);
    endtask
    initial begin
        cfg.cfg_we = 0; cfg.cfg_ch = '0; cfg.cfg_div = '0;
        model_reset();
        #12 check("reset");
        rst = 1'b1;
        for (int i = 0; i < 10; i++) cyc("t1_run", 1);
        #2 rst = 1'b0;
        model_reset();
        #1 check("t1_async_rst");
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 12; i++) cyc("t1_after", 1);
        cyc("t2_wr", 1, 0, 1, 1, 1);
        cyc("t2_clr", 1, 1);
        for (int i = 0; i < 8; i++) cyc("t2_min", 1);
        cyc("t3_wr4", 1, 1, 1, 2, 4);
        for (int i = 0; i < 6; i++) cyc("t3_run", 1);
        cyc("t3_wr2", 1, 0, 1, 2, 2);
        for (int i = 0; i < 14; i++) cyc("t3_reload", 1);
        cyc("t4_zero", 1, 0, 1, 0, 0);
        cyc("t4_badch", 1, 0, 1, 3, 2);
        for (int i = 0; i < 8; i++) cyc("t4_after", 1);
        cyc("t5_wr3", 1, 1, 1, 0, 3);
        cyc("t5_cnt1", 1);
        for (int i = 0; i < 10; i++) cyc("t5_pause", 0, 0, i == 4, 0, 6);
        for (int i = 0; i < 8; i++) cyc("t5_resume", 1);
        cyc("t6_w1", 1, 0, 1, 1, 5);
        cyc("t6_w2", 1, 0, 1, 2, 5);
        cyc("t6_clr", 1, 1, 1, 0, 5);
        for (int i = 0; i < 12; i++) cyc("t6_run", 1);
        for (int i = 0; i < 400; i++)
            cyc("rand", $urandom_range(9, 0) != 0, $urandom_range(40, 0) == 0,
                $urandom_range(3, 0) == 0, int'($urandom_range(3, 0)), int'($urandom_range(6, 0)));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
